out_port_buffer: RTL
====================

Name: out_port_buffer

Overview:
Output-side stage downstream of the accumulator microprocessor. It captures the 8-bit accumulator value each time the processor signals an output event and queues it in a small FIFO. It presents the queued words to an external consumer over a valid/ready handshake. It tracks processor halt so the system can tell when every produced word has been delivered.

Parameters:
WIDTH, 8, data width; matches the accumulator width.
DEPTH, 4, FIFO entries; must be a power of two and at least 2.
PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
clock  in  1  sole clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset; sampled on rising edge of clock.
acc_in  in  WIDTH  accumulator value from the processor.
out_strobe  in  1  one-cycle pulse: capture acc_in this cycle.
halt  in  1  processor halt level; stays high once reached.
dout  out  WIDTH  head-of-queue data.
dout_valid  out  1  dout holds a valid word.
dout_ready  in  1  consumer accepts dout this cycle.
overflow  out  1  sticky: at least one strobe was dropped.
drop_count  out  4  number of dropped strobes, saturating at 15.
word_count  out  8  words delivered to the consumer, wraps modulo 256.
done  out  1  halt seen and queue fully drained.

Behaviour:
- Reset (reset==0 at a clock edge): FIFO empty, read and write pointers 0, dout=0, dout_valid=0, overflow=0, drop_count=0, word_count=0, done=0, FSM=RUN. Reset overrides every other input in the same cycle, including mid-drain and simultaneous push/pop.
- FIFO is first-word fall-through:
  - dout_valid = (count != 0).
  - dout = mem[rd_ptr], or 0 when empty.
  - Pointers wrap modulo DEPTH.
  - Occupancy count ranges 0..DEPTH and uses PTR_W+1 bits.
- Pop: occurs when dout_valid && dout_ready at an edge. rd_ptr advances and word_count increments, wrapping 255->0.
- Push: occurs when out_strobe && accepting. mem[wr_ptr] <= acc_in and wr_ptr advances. A pushed word becomes visible on dout at the next cycle at the earliest; there is no same-cycle bypass.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, a push is accepted if a pop occurs in the same cycle.
  - When empty, only the push happens because dout_valid is 0.
- Full with no pop: a strobe is dropped, overflow is set and stays set until reset, and drop_count increments. drop_count holds at 15 once it reaches 15. Queue contents are unchanged.
- FSM states: RUN, DRAIN, DONE.
  - RUN: accepting=1. When halt==1, go to DRAIN. A strobe in the same cycle as the first halt is still accepted.
  - DRAIN: accepting=0. Strobes are ignored and are not counted as drops. Go to DONE when count==0, or when count==1 and a pop occurs.
  - DONE: done=1 and accepting=0. Stay in DONE until reset; halt deasserting has no effect.
  - done is registered: it is 1 exactly while FSM==DONE.
- out_strobe outside RUN is never recorded anywhere. dout_ready while empty has no effect.
- No combinational path from dout_ready to dout_valid.

Test Plan:
- Basic capture: after reset, strobe with acc_in=0x05, then 0x04 on the next cycle, dout_ready=1 -> dout shows 0x05 then 0x04 on consecutive cycles; word_count=2; dout_valid drops to 0 afterwards.
- Fill and overflow: dout_ready=0, strobe six times with values 0x10..0x15 -> queue holds 0x10..0x13; overflow=1; drop_count=2. Then drain -> dout sequence 0x10,0x11,0x12,0x13; word_count=4.
- Full with simultaneous push/pop: fill with 0xA0..0xA3, then in one cycle strobe 0xA4 and dout_ready=1 -> no drop, overflow stays 0; later output order is 0xA1,0xA2,0xA3,0xA4.
- Halt drain: queue holds 3 words, assert halt with dout_ready=0 and strobe 0x77 in that same cycle -> 0x77 is accepted. Subsequent strobes are ignored. Release dout_ready -> 4 words delivered, then done=1 in the following cycle.
- Reset mid-operation: queue holds 2 words with overflow=1, drive reset=0 together with a strobe and dout_ready=1 -> the next cycle shows all outputs at reset values and FSM in RUN. The value strobed during reset is not captured.
- Counter saturation and wrap: with dout_ready=0 and the queue full, issue 20 strobes -> drop_count=15. Separately push and pop 257 words -> word_count=1.

Source files
------------

// File: rtl/out_port_buffer_if.sv
// Producer/consumer bundle for the output port buffer: accumulator capture side,
// valid/ready delivery side and the drain/status flags.
interface out_port_buffer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] acc_in;
  logic             out_strobe;
  logic             halt;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overflow;
  logic [3:0]       drop_count;
  logic [7:0]       word_count;
  logic             done;

  modport master (
    output acc_in, out_strobe, halt, dout_ready,
    input  dout, dout_valid, overflow, drop_count, word_count, done
  );

  modport slave (
    input  acc_in, out_strobe, halt, dout_ready,
    output dout, dout_valid, overflow, drop_count, word_count, done
  );
endinterface

// File: rtl/out_port_buffer.sv
// Output port buffer: queues accumulator words on each output strobe in a small
// first-word fall-through FIFO and tracks processor halt until the queue drains.
module out_port_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic             clock,
  input logic             reset,
  out_port_buffer_if.slave bus
);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic [3:0]       drop_count_q, drop_count_d;
  logic [7:0]       word_count_q, word_count_d;
  logic             done_q, done_d;

  logic accepting_s, pop_s, push_req_s, full_s, push_s, drop_s;

  // Next-state computation for queue, counters, drain FSM and registered outputs.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    word_count_d = word_count_q;
    state_d      = state_q;

    accepting_s = (state_q == RUN);
    pop_s       = (count_q != {CNT_W{1'b0}}) && bus.dout_ready;
    push_req_s  = bus.out_strobe && accepting_s;
    full_s      = (count_q == CNT_W'(DEPTH));
    // A full queue still takes the new word when the head leaves in the same cycle.
    push_s      = push_req_s && (!full_s || pop_s);
    drop_s      = push_req_s && full_s && !pop_s;

    if (push_s) begin
      mem_d[wr_ptr_q] = bus.acc_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1'b1);
      word_count_d = word_count_q + 8'd1;
    end else begin
      rd_ptr_d     = rd_ptr_q;
      word_count_d = word_count_q;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_count_q != 4'hF) begin
        drop_count_d = drop_count_q + 4'd1;
      end else begin
        drop_count_d = drop_count_q;
      end
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end

    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

    case (state_q)
      RUN: begin
        if (bus.halt) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (count_d == {CNT_W{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase

    dout_valid_d = (count_d != {CNT_W{1'b0}});
    if (dout_valid_d) begin
      dout_d = mem_d[rd_ptr_d];
    end else begin
      dout_d = {WIDTH{1'b0}};
    end
    done_d = (state_d == DONE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= RUN;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      dout_q       <= {WIDTH{1'b0}};
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 4'd0;
      word_count_q <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;
  assign bus.word_count = word_count_q;
  assign bus.done       = done_q;
endmodule
